regbank_wr_arbiter: RTL and testbench

Shares the single write port of the 4 x 8-bit register bank between two requesters. The requesters are the core writeback path and a debug/loader port. Core writeback has fixed priority. A starvation counter forces one debug grant after STARVE_LIMIT consecutive blocked cycles, stalling the core for that cycle. The block sits between the writeback stage, the debug interface and the register bank write inputs (RegWrite, WriteReg, WriteData).

---
 rtl/regbank_wr_arbiter.sv | 90 +++++++++
 tb/tb_regbank_wr_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/regbank_wr_arbiter.sv
// regbank_wr_arbiter: shares the register-bank write port between core writeback (priority)
// and a debug/loader port, with a starvation counter that forces one debug grant. Rev 1.0
`default_nettype none

module regbank_wr_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_W        = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       core_we,
  input  logic [1:0] core_addr,
  input  logic [7:0] core_data,
  output logic       core_stall,
  input  logic       dbg_valid,
  input  logic [1:0] dbg_addr,
  input  logic [7:0] dbg_data,
  output logic       dbg_ready,
  output logic       RegWrite,
  output logic [1:0] WriteReg,
  output logic [7:0] WriteData,
  output logic [7:0] dbg_wr_count
);

  localparam logic [0:0]       NORMAL   = 1'b0;
  localparam logic [0:0]       FORCE    = 1'b1;
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] wait_cnt;
  logic             grant_core;
  logic             grant_dbg;
  logic             blocked;

  // Grants are forced low during reset so the bank sees no write.
  always_comb begin
    grant_core = 1'b0;
    grant_dbg  = 1'b0;
    if (!reset) begin
      if (state == FORCE) begin
        grant_dbg  = dbg_valid;
        grant_core = core_we & ~dbg_valid;
      end else begin
        grant_core = core_we;
        grant_dbg  = dbg_valid & ~core_we;
      end
    end
  end

  assign blocked    = dbg_valid & ~grant_dbg;
  assign RegWrite   = grant_core | grant_dbg;
  assign dbg_ready  = grant_dbg;
  assign core_stall = core_we & ~grant_core & ~reset;
  assign WriteReg   = reset ? 2'd0 : (grant_dbg ? dbg_addr : core_addr);
  assign WriteData  = reset ? 8'd0 : (grant_dbg ? dbg_data : core_data);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= NORMAL;
      wait_cnt     <= '0;
      dbg_wr_count <= 8'd0;
    end else begin
      if (grant_dbg) begin
        dbg_wr_count <= dbg_wr_count + 8'd1;
      end
      case (state)
        FORCE: begin
          // A forced slot lasts one cycle whether or not debug is still asking.
          state    <= NORMAL;
          wait_cnt <= '0;
        end
        default: begin
          if (blocked) begin
            if (wait_cnt == LIMIT_M1) begin
              state    <= FORCE;
              wait_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end else begin
            wait_cnt <= '0;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regbank_wr_arbiter.sv
// Scoreboard bench for regbank_wr_arbiter: a stimulus process pushes expected outputs from a
// streak-counting reference model, and a negedge monitor pops and compares them.
`default_nettype none

module tb_regbank_wr_arbiter;

  localparam int LIMIT = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       core_we;
  logic [1:0] core_addr;
  logic [7:0] core_data;
  logic       core_stall;
  logic       dbg_valid;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;
  logic       dbg_ready;
  logic       RegWrite;
  logic [1:0] WriteReg;
  logic [7:0] WriteData;
  logic [7:0] dbg_wr_count;

  regbank_wr_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clock(clock), .reset(reset),
    .core_we(core_we), .core_addr(core_addr), .core_data(core_data), .core_stall(core_stall),
    .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .dbg_wr_count(dbg_wr_count)
  );

  always #5 clock = ~clock;

  // Register bank driven by the arbiter outputs.
  logic [7:0] bank [4];
  initial for (int i = 0; i < 4; i++) bank[i] = 8'd0;
  always @(posedge clock) if (RegWrite) bank[WriteReg] <= WriteData;

  typedef struct {
    string      tag;
    logic       rw;
    logic [1:0] wa;
    logic [7:0] wd;
    logic       rdy;
    logic       stl;
    logic [7:0] cnt;
    logic [31:0] bk;
  } exp_t;

  exp_t q[$];
  int total  = 0;
  int passed = 0;

  // Reference model state: length of current blocked streak, pending forced slot.
  int         m_run   = 0;
  bit         m_force = 0;
  int         m_cnt   = 0;
  logic [7:0] m_bank [4];
  initial for (int i = 0; i < 4; i++) m_bank[i] = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc(input string tag, input bit rst, input bit cwe, input logic [1:0] ca,
                     input logic [7:0] cd, input bit dv, input logic [1:0] da, input logic [7:0] dd);
    exp_t e;
    bit gd, gc;
    @(posedge clock);
    #1;
    reset = rst; core_we = cwe; core_addr = ca; core_data = cd;
    dbg_valid = dv; dbg_addr = da; dbg_data = dd;
    e.tag = tag;
    e.cnt = 8'(m_cnt);
    e.bk  = {m_bank[3], m_bank[2], m_bank[1], m_bank[0]};
    if (rst) begin
      e.rw = 0; e.wa = 0; e.wd = 0; e.rdy = 0; e.stl = 0;
      m_run = 0; m_force = 0; m_cnt = 0;
    end else begin
      gd = dv && (m_force || !cwe);
      gc = cwe && !gd;
      e.rw  = gc || gd;
      e.wa  = gd ? da : ca;
      e.wd  = gd ? dd : cd;
      e.rdy = gd;
      e.stl = cwe && !gc;
      if (gd || gc) m_bank[gd ? da : ca] = gd ? dd : cd;
      if (m_force) begin
        m_force = 0;
        m_run   = 0;
      end else if (dv && !gd) begin
        m_run++;
        if (m_run == LIMIT) begin
          m_force = 1;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
      m_cnt = (m_cnt + (gd ? 1 : 0)) % 256;
    end
    q.push_back(e);
  endtask

  // Monitor: the DUT presents a result every cycle; compare it mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.tag, ".RegWrite"},  32'(RegWrite),     32'(e.rw));
        check({e.tag, ".WriteReg"},  32'(WriteReg),     32'(e.wa));
        check({e.tag, ".WriteData"}, 32'(WriteData),    32'(e.wd));
        check({e.tag, ".dbg_ready"}, 32'(dbg_ready),    32'(e.rdy));
        check({e.tag, ".core_stall"},32'(core_stall),   32'(e.stl));
        check({e.tag, ".count"},     32'(dbg_wr_count), 32'(e.cnt));
        check({e.tag, ".bank"}, {bank[3], bank[2], bank[1], bank[0]}, e.bk);
      end
    end
  end

  initial begin
    reset = 1; core_we = 0; core_addr = 0; core_data = 0;
    dbg_valid = 0; dbg_addr = 0; dbg_data = 0;
    repeat (2) @(posedge clock);
    cyc("rst", 1, 1, 2'd1, 8'hFF, 1, 2'd2, 8'hEE);

    // Core only, then idle to observe the bank.
    cyc("core", 0, 1, 2'd2, 8'h5A, 0, 2'd0, 8'h00);
    cyc("idle", 0, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
    // Debug only.
    cyc("dbg",  0, 0, 2'd0, 8'h00, 1, 2'd1, 8'hC3);
    cyc("idle", 0, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
    // Starvation: forced grant every LIMIT+1 cycles.
    for (int i = 0; i < 9; i++) cyc("starve", 0, 1, 2'd0, 8'(8'h20 + i), 1, 2'd3, 8'h11);
    cyc("idle", 0, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
    // Withdraw debug on the would-be forced cycle.
    for (int i = 0; i < 3; i++) cyc("wd_blk", 0, 1, 2'd1, 8'h40, 1, 2'd2, 8'h77);
    cyc("wd_drop", 0, 1, 2'd1, 8'h41, 0, 2'd2, 8'h77);
    cyc("wd_after", 0, 1, 2'd1, 8'h42, 1, 2'd2, 8'h78);
    cyc("idle", 0, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
    // Reset mid-starvation: streak restarts from zero afterwards.
    for (int i = 0; i < 2; i++) cyc("rs_blk", 0, 1, 2'd0, 8'h50, 1, 2'd3, 8'h99);
    cyc("rs_rst", 1, 1, 2'd0, 8'h50, 1, 2'd3, 8'h99);
    for (int i = 0; i < 5; i++) cyc("rs_post", 0, 1, 2'd0, 8'h51, 1, 2'd3, 8'h9A);
    cyc("idle", 0, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
    // Counter wrap: 256 debug writes from zero.
    cyc("wr_rst", 1, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
    for (int i = 0; i < 256; i++) cyc("wrap", 0, 0, 2'd0, 8'h00, 1, 2'(i), 8'(i));
    cyc("wrap_end", 0, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
    // Random traffic with sticky-ish requests and occasional reset.
    for (int i = 0; i < 500; i++) begin
      cyc("rand", ($urandom_range(0, 60) == 0), ($urandom_range(0, 3) != 0), 2'($urandom),
          8'($urandom), ($urandom_range(0, 2) != 0), 2'($urandom), 8'($urandom));
    end
    cyc("idle", 0, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00);

    repeat (2) @(posedge clock);
    check("drain", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
